clock_divider_bank: RTL and testbench

CLOCK_DIVIDER_BANK -- requirements
Module: clock_divider_bank

---
 rtl/clock_divider_bank.sv | 80 ++++++++
 tb/tb_clock_divider_bank.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/clock_divider_bank.sv
`default_nettype none
// =============================================================================
// Module   : clock_divider_bank
// Purpose  : Bank of independent programmable divide-by-N tick/square-wave
//            generators sharing one system clock.
// Revision : 1.0
// =============================================================================
module clock_divider_bank #(
   parameter int CHANNELS = 4,      // number of independent divider channels (1..16)
   parameter int CNT_W    = 32,     // width of divisor and counter per channel
   parameter int DEF_DIV  = 50_000  // divisor loaded at reset (1 kHz at 50 MHz)
) (
   input  logic                      clk_in,
   input  logic                      rst,
   input  logic [CHANNELS-1:0]       en,
   input  logic                      sync,
   input  logic                      wr_en,
   input  logic [3:0]                wr_ch,
   input  logic [CNT_W-1:0]          wr_div,
   output logic [CHANNELS-1:0]       tick,
   output logic [CHANNELS-1:0]       clk_out,
   output logic [CHANNELS*CNT_W-1:0] div_q
);

   localparam logic [CNT_W-1:0] c_one     = CNT_W'(1);
   localparam logic [CNT_W-1:0] c_def_div = CNT_W'(DEF_DIV);

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      localparam logic [3:0] c_idx = 4'(i);

      logic [CNT_W-1:0] divisor_q, divisor_d;
      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic             tick_q, tick_d;
      logic             clk_out_q, clk_out_d;
      logic [CNT_W-1:0] last_cnt;
      logic [CNT_W-1:0] high_len;
      logic             wr_hit;
      logic             at_last;

      always_comb begin
         wr_hit    = wr_en && (wr_ch == c_idx);
         last_cnt  = divisor_q - c_one;
         // High phase is ceil(div/2) so odd divisors spend the extra cycle high.
         high_len  = (divisor_q >> 1) + {{(CNT_W-1){1'b0}}, divisor_q[0]};
         at_last   = (cnt_q == last_cnt);
         divisor_d = wr_hit ? wr_div : divisor_q;
         cnt_d     = cnt_q;
         tick_d    = 1'b0;
         clk_out_d = clk_out_q;
         if (wr_hit || sync || (divisor_q == '0)) begin
            cnt_d     = '0;
            clk_out_d = 1'b0;
         end else if (en[i]) begin
            cnt_d     = at_last ? '0 : (cnt_q + c_one);
            tick_d    = at_last;
            clk_out_d = (cnt_d < high_len);
         end
      end

      always_ff @(posedge clk_in) begin
         if (!rst) begin
            divisor_q <= c_def_div;
            cnt_q     <= '0;
            tick_q    <= 1'b0;
            clk_out_q <= 1'b0;
         end else begin
            divisor_q <= divisor_d;
            cnt_q     <= cnt_d;
            tick_q    <= tick_d;
            clk_out_q <= clk_out_d;
         end
      end

      assign div_q[i*CNT_W +: CNT_W] = divisor_q;
      assign tick[i]                 = tick_q;
      assign clk_out[i]              = clk_out_q;
   end

endmodule
`default_nettype wire

// File: tb/tb_clock_divider_bank.sv
`default_nettype none
// Testbench for clock_divider_bank: elapsed-cycle reference model feeding a
// scoreboard queue, plus directed pattern checks.
module tb_clock_divider_bank;

   localparam int NCH = 4;
   localparam int CW  = 16;
   localparam int DD  = 12;

   typedef struct packed {
      logic [NCH-1:0]    tk;
      logic [NCH-1:0]    co;
      logic [NCH*CW-1:0] dv;
   } exp_t;

   logic              clk_in = 1'b0;
   logic              rst;
   logic [NCH-1:0]    en;
   logic              sync;
   logic              wr_en;
   logic [3:0]        wr_ch;
   logic [CW-1:0]     wr_div;
   logic [NCH-1:0]    tick;
   logic [NCH-1:0]    clk_out;
   logic [NCH*CW-1:0] div_q;

   exp_t        sb_q[$];
   int unsigned mdiv[NCH];
   int unsigned elapsed[NCH];
   logic        mtick[NCH];
   logic        mclk[NCH];
   int          n_cmp = 0;
   int          n_bad = 0;

   clock_divider_bank #(.CHANNELS(NCH), .CNT_W(CW), .DEF_DIV(DD)) dut (
      .clk_in (clk_in),
      .rst    (rst),
      .en     (en),
      .sync   (sync),
      .wr_en  (wr_en),
      .wr_ch  (wr_ch),
      .wr_div (wr_div),
      .tick   (tick),
      .clk_out(clk_out),
      .div_q  (div_q)
   );

   always #5 clk_in = ~clk_in;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s @%0t: got %0h, want %0h", tag, $time, obs, exp);
      end
   endtask

   // Reference: phase = enabled cycles since restart, modulo divisor.
   task automatic predict();
      exp_t e;
      for (int c = 0; c < NCH; c++) begin
         if (!rst) begin
            mdiv[c] = DD; elapsed[c] = 0; mtick[c] = 1'b0; mclk[c] = 1'b0;
         end else if ((wr_en && int'(wr_ch) == c) || sync) begin
            if (wr_en && int'(wr_ch) == c) mdiv[c] = int'(wr_div);
            elapsed[c] = 0; mtick[c] = 1'b0; mclk[c] = 1'b0;
         end else if (mdiv[c] == 0) begin
            elapsed[c] = 0; mtick[c] = 1'b0; mclk[c] = 1'b0;
         end else if (en[c]) begin
            elapsed[c]++;
            mtick[c] = ((elapsed[c] % mdiv[c]) == 0);
            mclk[c]  = ((elapsed[c] % mdiv[c]) < ((mdiv[c] + 1) / 2));
         end else begin
            mtick[c] = 1'b0;
         end
         e.tk[c]           = mtick[c];
         e.co[c]           = mclk[c];
         e.dv[c*CW +: CW]  = CW'(mdiv[c]);
      end
      sb_q.push_back(e);
   endtask

   task automatic step();
      exp_t e;
      predict();
      @(posedge clk_in);
      #1;
      e = sb_q.pop_front();
      check_eq("tick",    64'(tick),    64'(e.tk));
      check_eq("clk_out", 64'(clk_out), 64'(e.co));
      check_eq("div_q",   64'(div_q),   64'(e.dv));
   endtask

   task automatic run(input int n);
      for (int k = 0; k < n; k++) step();
   endtask

   task automatic write_div(input logic [3:0] ch, input logic [CW-1:0] d);
      wr_en = 1'b1; wr_ch = ch; wr_div = d;
      step();
      wr_en = 1'b0;
   endtask

   initial begin
      logic [7:0] pat_clk;
      logic [7:0] pat_tick;
      pat_clk  = 8'b1001_1001;
      pat_tick = 8'b0001_0001;
      rst = 1'b0; en = '0; sync = 1'b0; wr_en = 1'b0; wr_ch = '0; wr_div = '0;

      run(2);
      check_eq("rst_div",  64'(div_q),   {4{16'd12}});
      check_eq("rst_tick", 64'(tick),    64'd0);
      check_eq("rst_clk",  64'(clk_out), 64'd0);
      rst = 1'b1;
      en  = 4'hF;

      // Odd, unity and zero divisors, then the basic divide-by-4 pattern
      write_div(4'd1, 16'd5);
      write_div(4'd2, 16'd1);
      write_div(4'd3, 16'd0);
      write_div(4'd0, 16'd4);
      for (int k = 0; k < 8; k++) begin
         step();
         check_eq("ch0_clk_pat",  64'(clk_out[0]), 64'(pat_clk[7-k]));
         check_eq("ch0_tick_pat", 64'(tick[0]),    64'(pat_tick[7-k]));
      end
      check_eq("div1_div0_tick", 64'(tick[3:2]),    64'(2'b01));
      check_eq("div1_div0_clk",  64'(clk_out[3:2]), 64'(2'b01));
      run(12);

      // Enable gating on channel 2 mid-period
      write_div(4'd2, 16'd6);
      run(3);
      en = 4'b1011;
      for (int k = 0; k < 7; k++) begin
         step();
         check_eq("gap_tick2", 64'(tick[2]), 64'd0);
      end
      en = 4'hF;
      run(10);

      // Sync coincident with a divisor write
      write_div(4'd0, 16'd3);
      write_div(4'd1, 16'd4);
      write_div(4'd2, 16'd6);
      write_div(4'd3, 16'd10);
      run(5);
      sync = 1'b1; wr_en = 1'b1; wr_ch = 4'd3; wr_div = 16'd8;
      step();
      sync = 1'b0; wr_en = 1'b0;
      for (int k = 1; k <= 24; k++) begin
         step();
         if (k == 12) check_eq("sync_tick12", 64'(tick), 64'(4'b0111));
         if (k == 24) check_eq("sync_tick24", 64'(tick), 64'(4'b1111));
      end

      // Mid-operation reset, then first tick after release
      run(3);
      rst = 1'b0;
      step();
      check_eq("mid_rst_div", 64'(div_q), {4{16'd12}});
      check_eq("mid_rst_out", 64'({tick, clk_out}), 64'd0);
      rst = 1'b1;
      for (int k = 1; k <= DD; k++) begin
         step();
         if (k == DD - 1) check_eq("rel_tick_early", 64'(tick), 64'd0);
         if (k == DD)     check_eq("rel_tick_first", 64'(tick), 64'(4'hF));
      end

      // Out-of-range channel write is ignored
      write_div(4'd5, 16'd7);
      check_eq("bad_wr_div", 64'(div_q), {4{16'd12}});
      run(4);

      check_eq("sb_empty", 64'(sb_q.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
